// File: rtl/buffer_seq_pkg.sv
// Shared types and helpers for the BufferMemory load/drain sequencer.
package buffer_seq_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, FETCH, PRESENT} state_t;

  // Row requests larger than the SRAM depth are limited to 2^a rows.
  function automatic int unsigned clampRows(input int unsigned load_rows, input int unsigned a);
    int unsigned limit;
    limit = 32'd1 << a;
    return (load_rows > limit) ? limit : load_rows;
  endfunction

endpackage

// File: rtl/buffer_sequencer.sv
// Load/drain sequencer: scatters a word stream round-robin over D banks, then sweeps rows out.
// Optional macro BUFSEQ_REPLAY_EN adds a replay input that re-drains the last loaded job.
module buffer_sequencer
  import buffer_seq_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int A     = 7,
  parameter int W     = 16,
  localparam int D    = 1 << DEPTH
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             start,
  input  logic [A:0]       loadRows,
`ifdef BUFSEQ_REPLAY_EN
  input  logic             replay,
`endif
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic [A-1:0]     mem_address,
  output logic             mem_write,
  output logic             mem_ioSelect,
  output logic [DEPTH-1:0] mem_ioBankSelect,
  output logic [W-1:0]     mem_ioInput,
  input  logic [W*D-1:0]   mem_op,
  output logic             out_valid,
  output logic [W*D-1:0]   out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  localparam int RW = A + 1;

  state_t         state, next_state;
  logic [A-1:0]     row_cnt;
  logic [DEPTH-1:0] bank_cnt;
  logic [A:0]       rows;
  logic             done_q;

  logic accept, present_hs, last_row, last_bank;
  logic start_job, start_empty, replay_job;

  assign accept      = (state == LOAD) && in_valid;
  assign present_hs  = (state == PRESENT) && out_ready;
  assign last_row    = ({1'b0, row_cnt} == (rows - 1'b1));
  assign last_bank   = &bank_cnt;
  assign start_job   = (state == IDLE) && start && (loadRows != '0);
  assign start_empty = (state == IDLE) && start && (loadRows == '0);
`ifdef BUFSEQ_REPLAY_EN
  // start outranks replay; replay needs a previously latched row count.
  assign replay_job  = (state == IDLE) && !start && replay && (rows != '0);
`else
  assign replay_job  = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RSTn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start_job)       next_state = LOAD;
        else if (replay_job) next_state = FETCH;
      end
      LOAD:    if (accept && last_bank && last_row) next_state = FETCH;
      FETCH:   next_state = PRESENT;
      PRESENT: if (present_hs) next_state = last_row ? IDLE : FETCH;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      row_cnt  <= '0;
      bank_cnt <= '0;
      rows     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (present_hs && last_row) || start_empty;
      if (start_job) begin
        rows     <= RW'(clampRows(32'(loadRows), A));
        row_cnt  <= '0;
        bank_cnt <= '0;
      end else if (replay_job) begin
        row_cnt <= '0;
      end else if (accept) begin
        bank_cnt <= bank_cnt + 1'b1;
        if (last_bank) row_cnt <= last_row ? '0 : row_cnt + 1'b1;
      end else if (present_hs) begin
        row_cnt <= last_row ? '0 : row_cnt + 1'b1;
      end
    end
  end

  // Address stays on row_cnt through PRESENT so mem_op holds under backpressure.
  always_comb begin
    in_ready     = (state == LOAD);
    mem_ioSelect = (state == LOAD);
    mem_write    = accept;
    mem_address  = (state == IDLE) ? '0 : row_cnt;
    out_valid    = (state == PRESENT);
    busy         = (state != IDLE);
  end

  assign mem_ioBankSelect = bank_cnt;
  assign mem_ioInput      = in_data;
  assign out_data         = mem_op;
  assign done             = done_q;

endmodule
